// File: rtl/vm_pkg.sv
// Shared definitions for the vending purchase controller: FSM state encoding,
// coin-code constants and the default item price.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } state_e;

  localparam logic [1:0] COIN_0 = 2'b00;
  localparam logic [1:0] COIN_1 = 2'b01;
  localparam logic [1:0] COIN_2 = 2'b10;
  localparam logic [1:0] COIN_5 = 2'b11;

  localparam logic [3:0] DEFAULT_PRICE = 4'd3;

endpackage

// File: rtl/coin_decoder.sv
// Combinational map from the 2-bit coin code to its value in credit units.
module coin_decoder
  import vm_pkg::*;
(
  input  logic [1:0] coin_code_i,
  output logic [3:0] coin_value_o
);

  always_comb begin
    case (coin_code_i)
      COIN_1:  coin_value_o = 4'd1;
      COIN_2:  coin_value_o = 4'd2;
      COIN_5:  coin_value_o = 4'd5;
      default: coin_value_o = 4'd0;
    endcase
  end

endmodule

// File: rtl/purchase_controller.sv
// Vending purchase controller: owner restock, coin collection, dispense with
// change, and refund. All outputs except empty_light are registered.
module purchase_controller
  import vm_pkg::*;
#(
  parameter logic [3:0] PRICE = DEFAULT_PRICE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       load,
  input  logic [3:0] new_supply,
  input  logic       coin_valid,
  input  logic [1:0] coin_code,
  input  logic       select,
  input  logic       cancel,
  output logic [3:0] stock,
  output logic [3:0] credit,
  output logic       dispense,
  output logic [3:0] change,
  output logic       change_valid,
  output logic       coin_reject,
  output logic       empty_light
);

  state_e     state_q, state_d;
  logic [3:0] stock_q, stock_d;
  logic [3:0] credit_q, credit_d;
  logic [3:0] change_q, change_d;
  logic       dispense_q, dispense_d;
  logic       change_valid_q, change_valid_d;
  logic       coin_reject_q, coin_reject_d;

  logic [3:0] coin_value;
  logic [4:0] credit_sum;

  coin_decoder u_coin_decoder (
    .coin_code_i  (coin_code),
    .coin_value_o (coin_value)
  );

  // Extra bit detects a coin that would push credit past 15.
  assign credit_sum = {1'b0, credit_q} + {1'b0, coin_value};

  always_comb begin
    // NOTE: every _d gets a default before the case, so no path can infer a latch.
    state_d        = state_q;
    stock_d        = stock_q;
    credit_d       = credit_q;
    change_d       = 4'd0;
    dispense_d     = 1'b0;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mode) begin
          if (load) stock_d = new_supply;
          coin_reject_d = coin_valid;
        end else if (coin_valid) begin
          if (stock_q != 4'd0) begin
            credit_d = credit_sum[3:0];
            state_d  = COLLECT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        // Abort outranks purchase; any coin arriving with a state exit goes back.
        if (cancel || mode) begin
          state_d        = REFUND;
          change_d       = credit_q;
          change_valid_d = 1'b1;
          credit_d       = 4'd0;
          coin_reject_d  = coin_valid;
        end else if (select && (credit_q >= PRICE) && (stock_q != 4'd0)) begin
          state_d        = DISPENSE;
          dispense_d     = 1'b1;
          stock_d        = stock_q - 4'd1;
          change_d       = credit_q - PRICE;
          change_valid_d = 1'b1;
          credit_d       = 4'd0;
          coin_reject_d  = coin_valid;
        end else if (coin_valid) begin
          if (credit_sum[4]) coin_reject_d = 1'b1;
          else               credit_d      = credit_sum[3:0];
        end
      end

      DISPENSE, REFUND: begin
        state_d       = IDLE;
        coin_reject_d = coin_valid;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      stock_q        <= 4'd0;
      credit_q       <= 4'd0;
      change_q       <= 4'd0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q        <= state_d;
      stock_q        <= stock_d;
      credit_q       <= credit_d;
      change_q       <= change_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
    end
  end

  assign stock        = stock_q;
  assign credit       = credit_q;
  assign change       = change_q;
  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign coin_reject  = coin_reject_q;
  assign empty_light  = (stock_q == 4'd0);

endmodule

// File: tb/tb_purchase_controller.sv
// Scoreboard bench for purchase_controller: stimulus queues expected pulse
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_purchase_controller;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic       load;
  logic [3:0] new_supply;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       select;
  logic       cancel;
  logic [3:0] stock;
  logic [3:0] credit;
  logic       dispense;
  logic [3:0] change;
  logic       change_valid;
  logic       coin_reject;
  logic       empty_light;

  typedef struct packed {
    logic       disp;
    logic       cv;
    logic [3:0] chg;
    logic       rej;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  purchase_controller #(.PRICE(4'd3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .load         (load),
    .new_supply   (new_supply),
    .coin_valid   (coin_valid),
    .coin_code    (coin_code),
    .select       (select),
    .cancel       (cancel),
    .stock        (stock),
    .credit       (credit),
    .dispense     (dispense),
    .change       (change),
    .change_valid (change_valid),
    .coin_reject  (coin_reject),
    .empty_light  (empty_light)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic ev_t ev(input logic d, input logic v, input logic [3:0] c, input logic r);
    ev_t e;
    e.disp = d;
    e.cv   = v;
    e.chg  = c;
    e.rej  = r;
    return e;
  endfunction

  // One clock: inputs set beforehand are sampled at this edge, strobes then drop.
  task automatic tick();
    @(posedge clk);
    #1;
    load       = 1'b0;
    coin_valid = 1'b0;
    select     = 1'b0;
    cancel     = 1'b0;
  endtask

  task automatic coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_code  = code;
    tick();
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (!change_valid) check("change_zero_when_invalid", {4'd0, change}, 8'd0);
      if (dispense || change_valid || coin_reject) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got disp=%0b cv=%0b chg=%0d rej=%0b, expected no event",
                   dispense, change_valid, change, coin_reject);
        end else begin
          e = exp_q.pop_front();
          total++;
          if ({dispense, change_valid, change, coin_reject} !== e) begin
            bad++;
            $display("FAIL event: got disp=%0b cv=%0b chg=%0d rej=%0b expected disp=%0b cv=%0b chg=%0d rej=%0b",
                     dispense, change_valid, change, coin_reject, e.disp, e.cv, e.chg, e.rej);
          end
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b1;
    mode       = 1'b0;
    load       = 1'b0;
    new_supply = 4'd0;
    coin_valid = 1'b0;
    coin_code  = 2'b00;
    select     = 1'b0;
    cancel     = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_stock", {4'd0, stock}, 8'd0);
    check("rst_credit", {4'd0, credit}, 8'd0);
    check("rst_pulses", {5'd0, dispense, change_valid, coin_reject}, 8'd0);
    check("rst_empty", {7'd0, empty_light}, 8'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Owner restock of 12
    mode = 1'b1; load = 1'b1; new_supply = 4'd12;
    tick();
    check("restock_stock", {4'd0, stock}, 8'd12);
    check("restock_empty", {7'd0, empty_light}, 8'd0);

    // 2 + 2 then select: change 1
    mode = 1'b0;
    coin(2'b10);
    check("credit_after_2", {4'd0, credit}, 8'd2);
    coin(2'b10);
    check("credit_after_4", {4'd0, credit}, 8'd4);
    exp_q.push_back(ev(1'b1, 1'b1, 4'd1, 1'b0));
    select = 1'b1;
    tick();
    check("buy1_stock", {4'd0, stock}, 8'd11);
    check("buy1_credit", {4'd0, credit}, 8'd0);
    tick();
    check("dispense_one_cycle", {7'd0, dispense}, 8'd0);

    // 5,5,5 then 1: saturation reject, then cancel refunds 15
    coin(2'b11);
    coin(2'b11);
    coin(2'b11);
    check("credit_15", {4'd0, credit}, 8'd15);
    exp_q.push_back(ev(1'b0, 1'b0, 4'd0, 1'b1));
    coin(2'b01);
    check("credit_held_15", {4'd0, credit}, 8'd15);
    exp_q.push_back(ev(1'b0, 1'b1, 4'd15, 1'b0));
    cancel = 1'b1;
    tick();
    check("refund15_credit", {4'd0, credit}, 8'd0);
    tick();

    // Select below price ignored, then exactly price gives change 0
    coin(2'b01);
    select = 1'b1;
    tick();
    check("select_below_price", {4'd0, credit}, 8'd1);
    coin(2'b10);
    check("credit_at_price", {4'd0, credit}, 8'd3);
    exp_q.push_back(ev(1'b1, 1'b1, 4'd0, 1'b0));
    select = 1'b1;
    tick();
    check("buy2_stock", {4'd0, stock}, 8'd10);
    tick();

    // Select and cancel together: refund 2, no dispense
    coin(2'b10);
    exp_q.push_back(ev(1'b0, 1'b1, 4'd2, 1'b0));
    select = 1'b1; cancel = 1'b1;
    tick();
    check("sel_cancel_stock", {4'd0, stock}, 8'd10);
    tick();

    // Coin arriving with cancel is rejected in the same event
    coin(2'b01);
    exp_q.push_back(ev(1'b0, 1'b1, 4'd1, 1'b1));
    cancel = 1'b1; coin_valid = 1'b1; coin_code = 2'b11;
    tick();
    tick();

    // Coin presented during DISPENSE is rejected
    coin(2'b10);
    coin(2'b10);
    exp_q.push_back(ev(1'b1, 1'b1, 4'd1, 1'b0));
    select = 1'b1;
    tick();
    check("buy3_stock", {4'd0, stock}, 8'd9);
    exp_q.push_back(ev(1'b0, 1'b0, 4'd0, 1'b1));
    coin(2'b01);
    check("dispense_coin_credit", {4'd0, credit}, 8'd0);

    // Owner mode: coin rejected; mode rising in COLLECT refunds
    mode = 1'b1;
    exp_q.push_back(ev(1'b0, 1'b0, 4'd0, 1'b1));
    coin(2'b10);
    check("owner_coin_credit", {4'd0, credit}, 8'd0);
    mode = 1'b0;
    coin(2'b10);
    exp_q.push_back(ev(1'b0, 1'b1, 4'd2, 1'b0));
    mode = 1'b1;
    tick();
    tick();
    mode = 1'b0; load = 1'b1; new_supply = 4'd7;
    tick();
    check("load_ignored_customer", {4'd0, stock}, 8'd9);
    coin(2'b01);
    exp_q.push_back(ev(1'b0, 1'b1, 4'd1, 1'b0));
    mode = 1'b1; load = 1'b1; new_supply = 4'd7;
    tick();
    check("load_ignored_collect", {4'd0, stock}, 8'd9);
    tick();

    // Empty machine rejects coins and stays in IDLE
    load = 1'b1; new_supply = 4'd0;
    tick();
    check("empty_stock", {4'd0, stock}, 8'd0);
    check("empty_light_on", {7'd0, empty_light}, 8'd1);
    mode = 1'b0;
    exp_q.push_back(ev(1'b0, 1'b0, 4'd0, 1'b1));
    coin(2'b01);
    check("empty_credit", {4'd0, credit}, 8'd0);
    select = 1'b1;
    tick();
    exp_q.push_back(ev(1'b0, 1'b0, 4'd0, 1'b1));
    coin(2'b10);
    check("empty_still_idle", {4'd0, credit}, 8'd0);

    // Sell the last item; stock reaches 0 without underflow
    mode = 1'b1; load = 1'b1; new_supply = 4'd1;
    tick();
    mode = 1'b0;
    coin(2'b11);
    exp_q.push_back(ev(1'b1, 1'b1, 4'd2, 1'b0));
    select = 1'b1;
    tick();
    check("last_item_stock", {4'd0, stock}, 8'd0);
    check("last_item_empty", {7'd0, empty_light}, 8'd1);
    tick();
    exp_q.push_back(ev(1'b0, 1'b0, 4'd0, 1'b1));
    coin(2'b01);
    check("sold_out_stock", {4'd0, stock}, 8'd0);

    // Reset mid-transaction discards credit with no refund pulse
    mode = 1'b1; load = 1'b1; new_supply = 4'd5;
    tick();
    mode = 1'b0;
    coin(2'b10);
    coin(2'b10);
    check("pre_reset_credit", {4'd0, credit}, 8'd4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_stock", {4'd0, stock}, 8'd0);
    check("midrst_credit", {4'd0, credit}, 8'd0);
    check("midrst_pulses", {5'd0, dispense, change_valid, coin_reject}, 8'd0);
    check("midrst_change", {4'd0, change}, 8'd0);
    check("midrst_empty", {7'd0, empty_light}, 8'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) tick();
    check("events_drained", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/purchase_controller.md
PURCHASE_CONTROLLER -- requirements
Module: purchase_controller

Interface
REQ-001 Parameter: PRICE, default 4'd3, item price in credit units; legal range 1..15.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: mode  input  1  1 = owner/restock mode, 0 = customer mode.
REQ-005 Port: load  input  1  owner strobe; commits new_supply into stock.
REQ-006 Port: new_supply  input  4  restocked quantity from the owner-supply stage.
REQ-007 Port: coin_valid  input  1  one coin presented this cycle.
REQ-008 Port: coin_code  input  2  coin value code: 00 = 0, 01 = 1, 10 = 2, 11 = 5 units.
REQ-009 Port: select  input  1  customer purchase request.
REQ-010 Port: cancel  input  1  customer abort request.
REQ-011 Port: stock  output  4  current item count, registered.
REQ-012 Port: credit  output  4  accumulated customer credit, registered.
REQ-013 Port: dispense  output  1  one-cycle item-release pulse, registered.
REQ-014 Port: change  output  4  returned amount; meaningful only while change_valid = 1.
REQ-015 Port: change_valid  output  1  one-cycle change-return pulse, registered.
REQ-016 Port: coin_reject  output  1  one-cycle pulse; presented coin returned unaccepted.
REQ-017 Port: empty_light  output  1  high whenever stock == 0; decoded from the stock register.

Function
REQ-018 FSM states SHALL be IDLE, COLLECT, DISPENSE, REFUND.
REQ-019 Owner mode: with mode = 1 and load = 1 in IDLE, stock SHALL take new_supply on that edge; load SHALL be ignored in any other state and when mode = 0.
REQ-020 In owner mode, any coin_valid SHALL produce coin_reject on the next cycle; select is ignored.
REQ-021 IDLE: a coin accepted with mode = 0 and stock != 0 SHALL add its value to credit and move to COLLECT; with stock == 0 it SHALL be rejected.
REQ-022 COLLECT: each accepted coin SHALL add to credit; a coin whose addition exceeds 15 SHALL be rejected and credit held (no wrap).
REQ-023 COLLECT: select with credit >= PRICE SHALL go to DISPENSE; select with credit < PRICE SHALL be ignored.
REQ-024 COLLECT: cancel SHALL go to REFUND; cancel wins over simultaneous select; a coin arriving with cancel SHALL be rejected.
REQ-025 COLLECT: mode rising to 1 SHALL go to REFUND, as for cancel.
REQ-026 DISPENSE (exactly one cycle): dispense = 1, stock decrements by 1, change = credit - PRICE, change_valid = 1 (also when change = 0), credit cleared; next state IDLE.
REQ-027 Latency: select sampled at edge N SHALL give dispense and change_valid high for cycle N+1 only.
REQ-028 REFUND (exactly one cycle): change = credit, change_valid = 1, credit cleared; next state IDLE.
REQ-029 A mode change during DISPENSE or REFUND SHALL NOT abort them; a transaction in progress always completes.
REQ-030 Coins presented during DISPENSE or REFUND SHALL be rejected.
REQ-031 stock SHALL never underflow; DISPENSE is unreachable with stock == 0.
REQ-032 change SHALL read 0 whenever change_valid = 0.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, stock = 0, credit = 0, change = 0, and dispense, change_valid and coin_reject all low; empty_light then reads 1.
REQ-034 Reset asserted mid-transaction SHALL discard credit without a refund pulse.

Structure
REQ-035 Shared package vm_pkg SHALL hold the state encoding, coin-code constants and the default PRICE.
REQ-036 Sub-module coin_decoder SHALL map coin_code to a 4-bit value, purely combinational.

Verification
REQ-037 Reset, then mode = 1, new_supply = 12 with load -> stock = 12, empty_light = 0.
REQ-038 mode = 0, coins 2 then 2, then select -> one dispense pulse, stock = 11, change = 1 with change_valid, credit = 0.
REQ-039 Coins 5,5,5 then 1 -> fourth coin rejected, credit = 15; cancel -> change = 15 with change_valid.
REQ-040 Stock = 0, coin 1 presented -> coin_reject pulse, credit stays 0, state stays IDLE.
REQ-041 credit = 2, select and cancel in the same cycle -> REFUND, change = 2, no dispense.
REQ-042 credit = 4, rst_n pulsed low -> all outputs return to reset values at once, with no change_valid.
